// File: rtl/fg_sram_arbiter.sv
// Foreground SRAM arbiter: fixed 2-cycle pixel reads with priority, FIFO-buffered writes.
// Optional FG_ARB_STARVE_FLAG_EN adds a sticky writer-starvation flag on wr_starved.
module fg_sram_arbiter #(
    parameter int RESOLUTION_X = 1920,
    parameter int RESOLUTION_Y = 1080,
    parameter int ADDR_WIDTH   = 21,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fg_pixel_request_active,
    input  logic signed [12:0]    fg_pixel_request_x,
    input  logic signed [12:0]    fg_pixel_request_y,
    output logic [15:0]           fg_pixel_in,
    output logic                  fg_pixel_skip,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]           sram_wdata,
    output logic                  sram_we,
    input  logic [15:0]           sram_rdata,
    output logic                  wr_starved
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [15:0]           mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  x_ok;
    logic                  y_ok;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  rd_tag;

    // Sign bit rules out negative coordinates; the remaining bits compare unsigned.
    assign x_ok = !fg_pixel_request_x[12] &&
                  (fg_pixel_request_x[11:0] < 12'(RESOLUTION_X));
    assign y_ok = !fg_pixel_request_y[12] &&
                  (fg_pixel_request_y[11:0] < 12'(RESOLUTION_Y));
    assign in_range = fg_pixel_request_active && x_ok && y_ok;

    assign rd_addr = ADDR_WIDTH'(fg_pixel_request_y[11:0]) *
                     ADDR_WIDTH'(RESOLUTION_X) +
                     ADDR_WIDTH'(fg_pixel_request_x[11:0]);

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !rst && !full;
    assign push     = wr_valid && wr_ready;
    assign pop      = !in_range && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= wr_addr;
            mem_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Address stage: a read owns the slot; otherwise the FIFO head may retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            rd_tag     <= 1'b0;
        end else begin
            sram_we <= 1'b0;
            rd_tag  <= in_range;
            if (in_range) begin
                sram_addr <= rd_addr;
            end else if (pop) begin
                sram_addr  <= mem_addr[rd_ptr];
                sram_wdata <= mem_data[rd_ptr];
                sram_we    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fg_pixel_in   <= '0;
            fg_pixel_skip <= 1'b1;
        end else begin
            fg_pixel_in   <= rd_tag ? sram_rdata : 16'h0000;
            fg_pixel_skip <= !rd_tag;
        end
    end

`ifdef FG_ARB_STARVE_FLAG_EN
    logic [15:0] starve_cnt;
    logic        starve_q;
    logic        starve_hit;

    assign starve_hit = (starve_cnt >= 16'd1024);
    assign wr_starved = starve_q || starve_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            starve_q   <= 1'b0;
        end else begin
            starve_q <= starve_q || starve_hit;
            if (pop)
                starve_cnt <= '0;
            else if (full && wr_valid && starve_cnt != 16'hFFFF)
                starve_cnt <= starve_cnt + 16'd1;
        end
    end
`else
    assign wr_starved = 1'b0;
`endif

endmodule
